// File: rtl/dds_pkg.sv
// Shared DDS definitions: command opcodes, load-controller state encoding
// and a small width helper used for byte counters.
package dds_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_STOP     = 2'b00,
    OP_LOAD_RAM = 2'b01,
    OP_LOAD_TW  = 2'b10,
    OP_RUN      = 2'b11
  } dds_op_e;

  // Load-controller states; the DDS datapath decodes RUN from this encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LOAD_RAM = 2'b01,
    ST_LOAD_TW  = 2'b10,
    ST_RUN      = 2'b11
  } dds_state_e;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dds_tw_shift.sv
// Tuning-word assembler: shifts stream bytes in MSB first, counts them and
// raises tw_valid once a complete word of TW_BYTES bytes has been loaded.
// start clears the counter and tw_valid; the word itself is overwritten by
// the following shifts, so it is left alone on start.
module dds_tw_shift
  import dds_pkg::*;
#(
  parameter int TW_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [8*TW_BYTES-1:0] tuning_word,
  output logic                  tw_valid,
  output logic                  last_byte
);

  localparam int TW_W  = 8 * TW_BYTES;
  localparam int CNT_W = cnt_width(TW_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TW_BYTES - 1);

  logic [TW_W-1:0]  tw_reg, tw_next;
  logic [TW_W-1:0]  tw_shifted;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             valid_reg, valid_next;

  // Shift-left-by-one-byte network: byte 0 takes the new byte, every higher
  // byte takes its lower neighbour (works for any TW_BYTES >= 1).
  genvar gi;
  generate
    for (gi = 0; gi < TW_BYTES; gi++) begin : g_byte
      if (gi == 0) begin : g_lsb
        assign tw_shifted[7:0] = byte_in;
      end else begin : g_upper
        assign tw_shifted[8*gi +: 8] = tw_reg[8*(gi-1) +: 8];
      end
    end
  endgenerate

  assign last_byte   = shift_en && (cnt_reg == CNT_LAST);
  assign tuning_word = tw_reg;
  assign tw_valid    = valid_reg;

  // Next-state: restart on start, otherwise shift and count accepted bytes.
  always_comb begin
    tw_next    = tw_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    if (start) begin
      cnt_next   = '0;
      valid_next = 1'b0;
    end else if (shift_en) begin
      tw_next = tw_shifted;
      if (cnt_reg == CNT_LAST) begin
        cnt_next   = '0;
        valid_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Word, byte counter and valid flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tw_reg    <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      tw_reg    <= tw_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
    end
  end

endmodule

// File: rtl/dds_load_ctrl.sv
// DDS load controller: sequences waveform-RAM loading, tuning-word loading
// and the RUN state that enables the phase accumulator.
// Optional macro DDS_CKSUM_EN adds a cksum output (XOR of the bytes written
// during the current RAM load).
// The stream is byte oriented: s_data[7:0] feeds the tuning-word shifter,
// so DATA_W is expected to be at least 8.
module dds_load_ctrl
  import dds_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int TW_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  output logic                  cmd_ready,
  input  logic                  s_valid,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  s_ready,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_full,
  output logic [8*TW_BYTES-1:0] tuning_word,
  output logic                  tw_valid,
  output logic                  phase_ena,
  output logic                  busy
`ifdef DDS_CKSUM_EN
  ,
  output logic [DATA_W-1:0]     cksum
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  dds_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              ram_full_reg, ram_full_next;
  // Remembers that the current tuning-word load was started from RUN.
  logic              ret_run_reg, ret_run_next;
  logic              tw_start;
  logic              tw_shift;
  logic              tw_last;
`ifdef DDS_CKSUM_EN
  logic [DATA_W-1:0] cksum_reg, cksum_next;
`endif

  // Tuning-word assembler; bytes reach it only while loading the word.
  dds_tw_shift #(
    .TW_BYTES (TW_BYTES)
  ) u_tw_shift (
    .clk         (clk),
    .reset       (reset),
    .start       (tw_start),
    .shift_en    (tw_shift),
    .byte_in     (s_data[7:0]),
    .tuning_word (tuning_word),
    .tw_valid    (tw_valid),
    .last_byte   (tw_last)
  );

  assign ram_addr  = addr_reg;
  assign ram_wdata = s_data;
  assign ram_full  = ram_full_reg;
  assign busy      = (state_reg != ST_IDLE);
`ifdef DDS_CKSUM_EN
  assign cksum     = cksum_reg;
`endif

  // Next-state and output decode; commands act on the following edge and
  // RAM writes are presented combinationally in the transfer cycle.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    ram_full_next = ram_full_reg;
    ret_run_next  = ret_run_reg;
    tw_start      = 1'b0;
    tw_shift      = 1'b0;
    cmd_ready     = 1'b0;
    s_ready       = 1'b0;
    ram_we        = 1'b0;
    phase_ena     = 1'b0;
`ifdef DDS_CKSUM_EN
    cksum_next    = cksum_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (dds_op_e'(cmd_op))
            OP_LOAD_RAM: begin
              state_next    = ST_LOAD_RAM;
              addr_next     = '0;
              ram_full_next = 1'b0;
`ifdef DDS_CKSUM_EN
              cksum_next    = '0;
`endif
            end
            OP_LOAD_TW: begin
              state_next   = ST_LOAD_TW;
              ret_run_next = 1'b0;
              tw_start     = 1'b1;
            end
            OP_RUN: begin
              // Only start the accumulator with a full table and a word.
              if (ram_full_reg && tw_valid) begin
                state_next = ST_RUN;
              end
            end
            default: begin
              state_next = ST_IDLE;
            end
          endcase
        end
      end

      ST_LOAD_RAM: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ram_we    = 1'b1;
          addr_next = addr_reg + ADDR_W'(1);
`ifdef DDS_CKSUM_EN
          cksum_next = cksum_reg ^ s_data;
`endif
          if (addr_reg == ADDR_LAST) begin
            // Last location written: table complete, counter wraps to 0.
            ram_full_next = 1'b1;
            state_next    = ST_IDLE;
          end
        end
      end

      ST_LOAD_TW: begin
        s_ready = 1'b1;
        if (s_valid) begin
          tw_shift = 1'b1;
          if (tw_last) begin
            state_next = ret_run_reg ? ST_RUN : ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        cmd_ready = 1'b1;
        phase_ena = 1'b1;
        if (cmd_valid) begin
          case (dds_op_e'(cmd_op))
            OP_STOP: begin
              state_next = ST_IDLE;
            end
            OP_LOAD_TW: begin
              // Retune on the fly; come back to RUN when the word is in.
              state_next   = ST_LOAD_TW;
              ret_run_next = 1'b1;
              tw_start     = 1'b1;
            end
            default: begin
              state_next = ST_RUN;
            end
          endcase
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Controller state registers; reset aborts any load immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      ram_full_reg <= 1'b0;
      ret_run_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      ram_full_reg <= ram_full_next;
      ret_run_reg  <= ret_run_next;
    end
  end

`ifdef DDS_CKSUM_EN
  // Running XOR of the bytes written in the current RAM load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cksum_reg <= '0;
    end else begin
      cksum_reg <= cksum_next;
    end
  end
`endif

endmodule

// File: tb/tb_dds_load_ctrl.sv
// Testbench for dds_load_ctrl (ADDR_W=4, DATA_W=8, TW_BYTES=4).
// Stimulus pushes expected RAM writes and completed tuning words into
// queues; a negedge monitor pops and compares them when the DUT shows them.
module tb_dds_load_ctrl;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int TW_BYTES = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  localparam int M_IDLE = 0;
  localparam int M_RAM  = 1;
  localparam int M_TW   = 2;
  localparam int M_RUN  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic              cmd_ready;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_full;
  logic [31:0]       tuning_word;
  logic              tw_valid;
  logic              phase_ena;
  logic              busy;
`ifdef DDS_CKSUM_EN
  logic [DATA_W-1:0] cksum;
`endif

  dds_load_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .TW_BYTES (TW_BYTES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ready   (cmd_ready),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_full    (ram_full),
    .tuning_word (tuning_word),
    .tw_valid    (tw_valid),
    .phase_ena   (phase_ena),
    .busy        (busy)
`ifdef DDS_CKSUM_EN
    ,
    .cksum       (cksum)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected responses: {addr, data} per RAM write, one word per completed load.
  logic [11:0] exp_wr_q[$];
  logic [31:0] exp_tw_q[$];

  // Behavioural model of the controller.
  int          m_state = M_IDLE;
  int          m_addr  = 0;
  int          m_cnt   = 0;
  bit          m_full  = 1'b0;
  bit          m_twv   = 1'b0;
  bit          m_ret_run = 1'b0;
  logic [31:0] m_tw    = '0;
  logic [7:0]  m_cksum = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  function automatic bit model_cmd_ready();
    return (m_state == M_IDLE) || (m_state == M_RUN);
  endfunction

  function automatic bit model_s_ready();
    return (m_state == M_RAM) || (m_state == M_TW);
  endfunction

  task automatic check_status(input string tag);
    check({tag, ".busy"},      64'(busy),      64'(m_state != M_IDLE));
    check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(model_cmd_ready()));
    check({tag, ".s_ready"},   64'(s_ready),   64'(model_s_ready()));
    check({tag, ".phase_ena"}, 64'(phase_ena), 64'(m_state == M_RUN));
    check({tag, ".ram_full"},  64'(ram_full),  64'(m_full));
    check({tag, ".tw_valid"},  64'(tw_valid),  64'(m_twv));
    if (m_twv) check({tag, ".tuning_word"}, 64'(tuning_word), 64'(m_tw));
`ifdef DDS_CKSUM_EN
    check({tag, ".cksum"}, 64'(cksum), 64'(m_cksum));
`endif
  endtask

  // Issue one command for one cycle and apply its effect to the model.
  task automatic send_cmd(input logic [1:0] op);
    int op_i;
    op_i = int'(op);
    check("cmd_ready_at_issue", 64'(cmd_ready), 64'(model_cmd_ready()));
    cmd_valid = 1'b1;
    cmd_op    = op;
    if (m_state == M_IDLE) begin
      if (op_i == 1) begin
        m_state = M_RAM; m_addr = 0; m_full = 1'b0; m_cksum = '0;
      end else if (op_i == 2) begin
        m_state = M_TW; m_cnt = 0; m_twv = 1'b0; m_ret_run = 1'b0;
      end else if (op_i == 3 && m_full && m_twv) begin
        m_state = M_RUN;
      end
    end else if (m_state == M_RUN) begin
      if (op_i == 0) begin
        m_state = M_IDLE;
      end else if (op_i == 2) begin
        m_state = M_TW; m_cnt = 0; m_twv = 1'b0; m_ret_run = 1'b1;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_status("after_cmd");
  endtask

  // Offer one byte for one cycle (s_valid left high for back-to-back use).
  task automatic stream_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    check("s_ready_at_offer", 64'(s_ready), 64'(model_s_ready()));
    if (m_state == M_RAM) begin
      exp_wr_q.push_back({4'(m_addr), b});
      m_cksum = m_cksum ^ b;
      m_addr++;
      if (m_addr == DEPTH) begin
        m_addr = 0; m_full = 1'b1; m_state = M_IDLE;
      end
    end else if (m_state == M_TW) begin
      m_tw = (m_tw << 8) | 32'(b);
      m_cnt++;
      if (m_cnt == TW_BYTES) begin
        m_twv = 1'b1;
        exp_tw_q.push_back(m_tw);
        m_state = m_ret_run ? M_RUN : M_IDLE;
      end
    end
    @(posedge clk); #1;
    check_status("after_byte");
  endtask

  task automatic stream_end();
    s_valid = 1'b0;
  endtask

  // Monitor: compare every DUT write and every newly completed word.
  logic        tw_valid_prev = 1'b0;
  logic [11:0] mon_wr;
  logic [31:0] mon_tw;
  always @(negedge clk) begin
    if (reset) begin
      if (ram_we) begin
        n_tests++;
        if (exp_wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL ram_write: unexpected write addr=%0d data=0x%0h", ram_addr, ram_wdata);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          if ({ram_addr, ram_wdata} !== mon_wr) begin
            n_fail++;
            $display("FAIL ram_write: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                     ram_addr, ram_wdata, mon_wr[11:8], mon_wr[7:0]);
          end else begin
            $display("[TB] write addr=%0d data=0x%0h", ram_addr, ram_wdata);
          end
        end
      end
      if (tw_valid && !tw_valid_prev) begin
        n_tests++;
        if (exp_tw_q.size() == 0) begin
          n_fail++;
          $display("FAIL tw_done: unexpected word 0x%0h", tuning_word);
        end else begin
          mon_tw = exp_tw_q.pop_front();
          if (tuning_word !== mon_tw) begin
            n_fail++;
            $display("FAIL tw_done: got 0x%0h, expected 0x%0h", tuning_word, mon_tw);
          end else begin
            $display("[TB] word 0x%0h", tuning_word);
          end
        end
      end
    end
    tw_valid_prev <= tw_valid;
  end

  task automatic model_reset();
    m_state = M_IDLE; m_addr = 0; m_cnt = 0; m_full = 1'b0;
    m_twv = 1'b0; m_ret_run = 1'b0; m_tw = '0; m_cksum = '0;
  endtask

  initial begin
    int r;
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset values.
    check("rst.tuning_word", 64'(tuning_word), 64'(0));
    check("rst.ram_we", 64'(ram_we), 64'(0));
    check_status("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Full RAM load, 17th byte must not be consumed.
    send_cmd(2'b01);
    for (int i = 0; i <= DEPTH; i++) stream_byte(8'(i));
    stream_end();
    check("ram_full_after_load", 64'(ram_full), 64'(1));

    // RUN without a tuning word stays idle.
    send_cmd(2'b11);
    check("run_no_tw.phase_ena", 64'(phase_ena), 64'(0));

    // Tuning word load then RUN.
    send_cmd(2'b10);
    stream_byte(8'h12); stream_byte(8'h34); stream_byte(8'h56); stream_byte(8'h78);
    stream_end();
    check("tw_directed", 64'(tuning_word), 64'(32'h12345678));
    send_cmd(2'b11);
    check("run.phase_ena", 64'(phase_ena), 64'(1));

    // Retune while running: phase_ena low during the load, back to RUN.
    send_cmd(2'b10);
    stream_byte(8'h00); stream_byte(8'h00); stream_byte(8'h01); stream_byte(8'h00);
    stream_end();
    check("retune.word", 64'(tuning_word), 64'(32'h00000100));
    check("retune.phase_ena", 64'(phase_ena), 64'(1));

    // LOAD_RAM and RUN ignored in RUN; STOP returns to IDLE.
    send_cmd(2'b01);
    send_cmd(2'b11);
    send_cmd(2'b00);

`ifdef DDS_CKSUM_EN
    send_cmd(2'b01);
    for (int i = 0; i < DEPTH; i++) stream_byte(8'h01);
    stream_end();
    check("cksum_all_ones", 64'(cksum), 64'(8'h00));
    send_cmd(2'b01);
    for (int i = 0; i < DEPTH; i++) stream_byte((i < 3) ? 8'(i + 1) : 8'h00);
    stream_end();
    check("cksum_1_2_3", 64'(cksum), 64'(8'h00));
    send_cmd(2'b01);
    for (int i = 0; i < DEPTH; i++) stream_byte((i == 0) ? 8'hA5 : 8'h00);
    stream_end();
    check("cksum_a5", 64'(cksum), 64'(8'hA5));
`endif

    // Randomized traffic, including ignored commands and stray bytes.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 3);
      if (model_s_ready() && r == 0) begin
        send_cmd(2'($urandom_range(0, 3)));
      end else if (model_s_ready() || r < 2) begin
        n = $urandom_range(1, 20);
        for (int k = 0; k < n; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
            check_status("gap");
          end
          stream_byte(8'($urandom_range(0, 255)));
        end
        stream_end();
      end else begin
        send_cmd(2'($urandom_range(0, 3)));
      end
    end
    while (model_s_ready()) stream_byte(8'($urandom_range(0, 255)));
    stream_end();

    // Reset in the middle of a RAM load.
    send_cmd(2'b01);
    for (int i = 0; i < 5; i++) stream_byte(8'(8'hC0 + i));
    s_valid = 1'b1;
    s_data  = 8'h55;
    reset   = 1'b0;
    model_reset();
    #1;
    check("midrst.ram_we", 64'(ram_we), 64'(0));
    check("midrst.tuning_word", 64'(tuning_word), 64'(0));
    check_status("midreset");
    @(posedge clk); #1;
    reset   = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    send_cmd(2'b01);
    for (int i = 0; i < DEPTH; i++) stream_byte(8'($urandom_range(0, 255)));
    stream_end();

    @(posedge clk); #1;
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
    check("tw_queue_drained", 64'(exp_tw_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
